// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic array slice: default array geometry,
// the packed result-vector type and the per-column deskew depth helper.
// The PE array top, the upstream skew feeder and the column deskew block
// all import this package so they agree on geometry.
// ---------------------------------------------------------------------------
package sa_pkg;

  // Default array geometry
  localparam int SA_N       = 4;
  localparam int SA_X_WIDTH = 16;
  localparam int SA_Y_WIDTH = SA_X_WIDTH + SA_X_WIDTH - 1;

  // One full N-wide result vector, element j = column j
  typedef logic [SA_N-1:0][SA_Y_WIDTH-1:0] sa_vec_t;

  // Column j leaves the array j cycles after column 0, so it needs
  // N-1-j cycles of delay to line up with the last column.
  function automatic int sa_delay_depth(input int n, input int j);
    return n - 1 - j;
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// ---------------------------------------------------------------------------
// sa_sync_fifo
// Single-clock FIFO holding aligned result vectors. Outputs come straight
// from flops (head entry of the storage array), so a push never falls
// through combinationally to o_data.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data (ignored when full unless popping)
//   i_data       entry to write
//   o_full       count == DEPTH
//   i_pop        remove head entry (ignored when empty)
//   o_empty      count == 0
//   o_count      occupancy, 0..DEPTH
//   o_data       head entry
// ---------------------------------------------------------------------------
module sa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  input  logic                     i_pop,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wrPtr;
  logic [AW-1:0]               r_rdPtr;
  logic [AW:0]                 r_count;
  logic                        w_doPush;
  logic                        w_doPop;

  // Full and empty come from the occupancy counter, so pointers can simply
  // wrap modulo DEPTH. A push into a full FIFO is still legal when the head
  // is leaving on the same edge: the write lands in the slot being freed.
  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  // Storage, pointers and occupancy all move on the same edge so o_count
  // reflects a push or pop immediately after the edge that performs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_data  = r_mem[r_rdPtr];

endmodule

// File: rtl/sa_col_deskew.sv
// ---------------------------------------------------------------------------
// sa_col_deskew
// Removes the diagonal skew from the bottom row of the systolic array and
// reassembles one N-wide result vector per input vector, buffering complete
// vectors in a FIFO because the array cannot be stalled.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_c_vld      per-column valid, bit j = column j
//   i_c          column results, slice j = [j*Y_WIDTH +: Y_WIDTH]
//   o_vld/i_rdy  aligned vector handshake, pop on o_vld & i_rdy
//   o_data       aligned vector, slice j = column j
//   o_count      FIFO occupancy
//   o_overflow   sticky: vector dropped because FIFO full
//   o_skew_err   sticky: some but not all delayed valids seen together
//   i_clr_err    synchronous clear of both sticky flags (set wins)
// ---------------------------------------------------------------------------
module sa_col_deskew
  import sa_pkg::*;
#(
  parameter int N       = SA_N,
  parameter int X_WIDTH = SA_X_WIDTH,
  parameter int Y_WIDTH = X_WIDTH + X_WIDTH - 1,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             i_c_vld,
  input  logic [N*Y_WIDTH-1:0]     i_c,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [N*Y_WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_skew_err,
  input  logic                     i_clr_err
);

  logic [N-1:0]              w_dlyVld;
  logic [N-1:0][Y_WIDTH-1:0] w_dlyData;
  logic                      w_allVld;
  logic                      w_anyVld;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_ovfSet;
  logic                      w_skewSet;
  logic                      r_overflow;
  logic                      r_skewErr;

  // Per-column delay lines: column j gets N-1-j stages so every column of
  // one input vector emerges on the same cycle as column N-1, which passes
  // straight through. Data flops are reset too so outputs are deterministic.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = sa_delay_depth(N, j);
    if (D == 0) begin : g_pass
      assign w_dlyVld[j]  = i_c_vld[j];
      assign w_dlyData[j] = i_c[j*Y_WIDTH +: Y_WIDTH];
    end else begin : g_dly
      logic [D-1:0]              r_vld;
      logic [D-1:0][Y_WIDTH-1:0] r_data;

      // Shift register, stage 0 nearest the array
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= '0;
          r_data <= '0;
        end else begin
          r_vld[0]  <= i_c_vld[j];
          r_data[0] <= i_c[j*Y_WIDTH +: Y_WIDTH];
          for (int s = 1; s < D; s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_data[s] <= r_data[s-1];
          end
        end
      end

      assign w_dlyVld[j]  = r_vld[D-1];
      assign w_dlyData[j] = r_data[D-1];
    end
  end

  // A beat is a complete vector only if every delayed valid is present;
  // a partial set means the upstream skew is broken, so nothing is written.
  assign w_allVld  = &w_dlyVld;
  assign w_anyVld  = |w_dlyVld;
  assign w_pop     = o_vld & i_rdy;
  assign w_ovfSet  = w_allVld & w_full & ~w_pop;
  assign w_skewSet = w_anyVld & ~w_allVld;

  sa_sync_fifo #(
    .WIDTH (N*Y_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_allVld),
    .i_data  (w_dlyData),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_count (o_count),
    .o_data  (o_data)
  );

  assign o_vld = ~w_empty;

  // Sticky error flags: a set event on the same edge as a clear wins, and
  // only an explicit clear or reset brings a flag back down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_skewErr  <= 1'b0;
    end else begin
      if (w_ovfSet)       r_overflow <= 1'b1;
      else if (i_clr_err) r_overflow <= 1'b0;
      if (w_skewSet)      r_skewErr  <= 1'b1;
      else if (i_clr_err) r_skewErr  <= 1'b0;
    end
  end

  assign o_overflow = r_overflow;
  assign o_skew_err = r_skewErr;

endmodule

// File: tb/tb_sa_col_deskew.sv
// ---------------------------------------------------------------------------
// tb_sa_col_deskew
// Drives skewed column streams into sa_col_deskew and compares every cycle
// against a queue-based model of the aligned-vector FIFO and error flags.
// ---------------------------------------------------------------------------
module tb_sa_col_deskew;
  import sa_pkg::*;

  localparam int N     = SA_N;
  localparam int Y     = SA_Y_WIDTH;
  localparam int DEPTH = 8;
  localparam int VW    = N * Y;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  i_c_vld = '0;
  logic [VW-1:0] i_c = '0;
  logic          o_vld;
  logic          i_rdy = 1'b0;
  logic [VW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_skew_err;
  logic          i_clr_err = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: FIFO as a queue of whole vectors, history of sampled
  // inputs (index d = sampled d edges ago), sticky flags.
  sa_vec_t      modelQ[$];
  logic [N-1:0] histV[N];
  logic [Y-1:0] histD[N][N];
  logic         modelOvf;
  logic         modelSkew;

  // Launch schedule: futV[d][j] = column j valid d cycles from now
  logic [N-1:0] futV[N];
  logic [Y-1:0] futD[N][N];

  always #5 clk = ~clk;

  sa_col_deskew #(
    .N       (N),
    .X_WIDTH (SA_X_WIDTH),
    .Y_WIDTH (Y),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_c_vld    (i_c_vld),
    .i_c        (i_c),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_skew_err (o_skew_err),
    .i_clr_err  (i_clr_err)
  );

  // Hard stop in case something stalls the initial block
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [VW-1:0] obs,
                             input logic [VW-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf  = 1'b0;
    modelSkew = 1'b0;
    for (int d = 0; d < N; d++) begin
      histV[d] = '0;
      futV[d]  = '0;
      for (int j = 0; j < N; j++) begin
        histD[d][j] = '0;
        futD[d][j]  = '0;
      end
    end
  endtask

  // Column j of a vector becomes usable N-1-j edges after it was sampled;
  // all columns usable together form one vector.
  task automatic modelEdge();
    logic [N-1:0] dv;
    sa_vec_t      dd;
    bit           popNow;
    bit           ovfSet;
    bit           skewSet;
    for (int d = N-1; d > 0; d--) begin
      histV[d] = histV[d-1];
      for (int j = 0; j < N; j++) histD[d][j] = histD[d-1][j];
    end
    histV[0] = i_c_vld;
    for (int j = 0; j < N; j++) histD[0][j] = i_c[j*Y +: Y];
    for (int j = 0; j < N; j++) begin
      dv[j] = histV[N-1-j][j];
      dd[j] = histD[N-1-j][j];
    end
    popNow  = (modelQ.size() != 0) && (i_rdy == 1'b1);
    ovfSet  = 1'b0;
    skewSet = 1'b0;
    if (popNow) void'(modelQ.pop_front());
    if (&dv) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(dd);
      else ovfSet = 1'b1;
    end else if (|dv) begin
      skewSet = 1'b1;
    end
    if (ovfSet) modelOvf = 1'b1;
    else if (i_clr_err) modelOvf = 1'b0;
    if (skewSet) modelSkew = 1'b1;
    else if (i_clr_err) modelSkew = 1'b0;
  endtask

  task automatic compareModel();
    checkOutput("count", VW'(o_count), VW'(modelQ.size()));
    checkOutput("vld", VW'(o_vld), VW'(modelQ.size() != 0));
    if (modelQ.size() != 0) checkOutput("data", o_data, modelQ[0]);
    checkOutput("overflow", VW'(o_overflow), VW'(modelOvf));
    checkOutput("skewErr", VW'(o_skew_err), VW'(modelSkew));
  endtask

  // Drive one cycle of inputs. A launch starts a new vector: column j is
  // presented j cycles later with data base+j, unless masked off by keep.
  task automatic applyStimulus(input bit launch, input int base,
                               input logic [N-1:0] keep, input logic rdy,
                               input logic clr);
    if (launch) begin
      for (int j = 0; j < N; j++) begin
        futV[j][j] = keep[j];
        futD[j][j] = Y'(base + j);
      end
    end
    i_c_vld = futV[0];
    for (int j = 0; j < N; j++) i_c[j*Y +: Y] = futD[0][j];
    for (int d = 0; d < N-1; d++) begin
      futV[d] = futV[d+1];
      for (int j = 0; j < N; j++) futD[d][j] = futD[d+1][j];
    end
    futV[N-1] = '0;
    for (int j = 0; j < N; j++) futD[N-1][j] = '0;
    i_rdy     = rdy;
    i_clr_err = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
    compareModel();
  endtask

  task automatic runCycle(input bit launch, input int base,
                          input logic [N-1:0] keep, input logic rdy,
                          input logic clr);
    applyStimulus(launch, base, keep, rdy, clr);
    stepCycle();
  endtask

  initial begin
    int steps;
    int maxCnt;
    int vldCycles;
    int col;
    logic [N-1:0] keep;

    modelReset();
    #12;
    checkOutput("rstVld", VW'(o_vld), '0);
    checkOutput("rstCount", VW'(o_count), '0);
    checkOutput("rstData", o_data, '0);
    checkOutput("rstOvf", VW'(o_overflow), '0);
    checkOutput("rstSkew", VW'(o_skew_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();

    // Single vector {1,2,3,4}: visible N cycles after column 0 is presented
    runCycle(1'b1, 1, '1, 1'b0, 1'b0);
    steps = 1;
    while (!o_vld && steps < 20) begin
      runCycle(1'b0, 0, '1, 1'b0, 1'b0);
      steps++;
    end
    checkOutput("latency", VW'(steps), VW'(N));
    checkOutput("singleData", o_data, {Y'(4), Y'(3), Y'(2), Y'(1)});
    runCycle(1'b0, 0, '1, 1'b0, 1'b0);
    runCycle(1'b0, 0, '1, 1'b1, 1'b0);
    checkOutput("singlePopCount", VW'(o_count), '0);

    // Streaming at one vector per cycle
    maxCnt = 0;
    vldCycles = 0;
    for (int k = 0; k < 16 + N + 2; k++) begin
      runCycle(k < 16, 100 * k, '1, 1'b1, 1'b0);
      if (int'(o_count) > maxCnt) maxCnt = int'(o_count);
      if (o_vld) vldCycles++;
    end
    checkOutput("streamMaxCount", VW'(maxCnt), VW'(1));
    checkOutput("streamVectors", VW'(vldCycles), VW'(16));

    // Overflow: 10 vectors into a stalled FIFO, drain, then clear
    for (int k = 0; k < 10 + N + 1; k++) runCycle(k < 10, 1000 + 100 * k, '1, 1'b0, 1'b0);
    checkOutput("ovfCount", VW'(o_count), VW'(DEPTH));
    checkOutput("ovfFlag", VW'(o_overflow), VW'(1));
    for (int k = 0; k < DEPTH + 1; k++) runCycle(1'b0, 0, '1, 1'b1, 1'b0);
    runCycle(1'b0, 0, '1, 1'b0, 1'b1);
    checkOutput("ovfCleared", VW'(o_overflow), '0);

    // Full FIFO with a simultaneous pop on the push edge
    for (int k = 0; k < DEPTH + N; k++) runCycle(k < DEPTH, 3000 + 100 * k, '1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) runCycle(i == 0, 5000, '1, i == N-1, 1'b0);
    checkOutput("fullPopCount", VW'(o_count), VW'(DEPTH));
    checkOutput("fullPopOvf", VW'(o_overflow), '0);
    for (int k = 0; k < DEPTH + 1; k++) runCycle(1'b0, 0, '1, 1'b1, 1'b0);

    // Skew error: column 2 missing from the middle vector
    for (int k = 0; k < 3 + N; k++) runCycle(k < 3, 7000 + 100 * k, (k == 1) ? 4'b1011 : 4'b1111, 1'b1, 1'b0);
    checkOutput("skewSet", VW'(o_skew_err), VW'(1));
    for (int i = 0; i < N; i++) runCycle(i == 0, 8000, 4'b1011, 1'b1, 1'b1);
    checkOutput("skewSetWins", VW'(o_skew_err), VW'(1));
    runCycle(1'b0, 0, '1, 1'b1, 1'b1);
    checkOutput("skewCleared", VW'(o_skew_err), '0);

    // Reset with three vectors buffered and two still in the delay lines
    for (int k = 0; k < 6; k++) runCycle(k < 5, 9000 + 100 * k, '1, 1'b0, 1'b0);
    checkOutput("preRstCount", VW'(o_count), VW'(3));
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    i_c_vld = '0;
    i_c = '0;
    checkOutput("midRstVld", VW'(o_vld), '0);
    checkOutput("midRstCount", VW'(o_count), '0);
    checkOutput("midRstData", o_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    for (int k = 0; k < N + 2; k++) runCycle(k == 0, 11000, '1, 1'b0, 1'b0);
    checkOutput("postRstCount", VW'(o_count), VW'(1));
    for (int k = 0; k < 2; k++) runCycle(1'b0, 0, '1, 1'b1, 1'b0);

    // Randomized traffic with occasional skew faults, stalls and clears
    for (int k = 0; k < 600; k++) begin
      keep = '1;
      if ($urandom_range(19, 0) == 0) begin
        col = int'($urandom_range(N-1, 0));
        keep[col] = 1'b0;
      end
      runCycle($urandom_range(9, 0) < 6, int'($urandom & 32'h0FFF_FFFF), keep,
               $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
    end
    for (int k = 0; k < DEPTH + N + 2; k++) runCycle(1'b0, 0, '1, 1'b1, 1'b0);
    checkOutput("finalEmpty", VW'(o_count), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sa_col_deskew.md
Name: sa_col_deskew

Overview:
- Sits directly downstream of the bottom row of the systolic PE array. It consumes the N column result streams (c valid + c data) emerging from the last PE row.
- Column j's result for input vector k arrives one cycle later than column j-1's. The block removes that diagonal skew and reassembles one full N-wide result vector per input vector.
- Completed vectors are buffered in a FIFO with valid/ready output, because the array cannot be stalled.
- Overflow and skew-mismatch conditions are flagged as sticky errors.

Parameters:
- N, 4, number of array columns (>=2).
- X_WIDTH, 16, PE operand width.
- Y_WIDTH, X_WIDTH+X_WIDTH-1, column result width.
- DEPTH, 8, FIFO depth in vectors; power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_c_vld  in  N  per-column result valid from bottom PE row; bit j = column j
- i_c  in  N*Y_WIDTH  column results; slice j = bits [j*Y_WIDTH +: Y_WIDTH]
- o_vld  out  1  aligned vector available
- i_rdy  in  1  downstream accepts vector when o_vld & i_rdy
- o_data  out  N*Y_WIDTH  aligned vector; slice j = column j
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: aligned vector dropped because FIFO full
- o_skew_err  out  1  sticky: partial aligned valid detected
- i_clr_err  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset/clock: one clock domain, clk. rst_n is asynchronous active-low and clears all flops. Reset values: o_vld=0, o_count=0, o_overflow=0, o_skew_err=0, o_data=0.
- Delay lines:
  - Column j passes through exactly N-1-j register stages (valid and data together). Column N-1 has zero stages.
  - All valid flops are reset. Data flops are reset as well, for determinism.
- Alignment:
  - aligned_vld = AND of all delayed valids.
  - If any delayed valid is 1 but not all are, set o_skew_err on the next edge and write nothing for that beat.
- Push: aligned_vld pushes the concatenated delayed data into the FIFO.
- FIFO:
  - Registered output, no combinational fall-through.
  - A column N-1 sample at edge t (with matching earlier columns) makes o_vld=1 after edge t+1 when the FIFO was empty. End-to-end latency from column 0 is N cycles; from column N-1 it is 1 cycle.
  - o_data holds the head entry and is stable while o_vld & !i_rdy.
  - Pop on o_vld & i_rdy.
  - o_count updates on the same edge as push/pop: +1 on push only, -1 on pop only, unchanged on both.
- Full:
  - Push with count==DEPTH and no pop: drop the vector, leave contents untouched, set o_overflow.
  - Push with count==DEPTH and a simultaneous pop: accept the push, count stays DEPTH, no overflow.
- Empty: pop is impossible since o_vld=0; i_rdy is ignored.
- Pointers: read/write pointers wrap modulo DEPTH. Full and empty are distinguished by count, or by an extra pointer bit.
- Error flags:
  - i_clr_err clears both flags.
  - If a set event and i_clr_err coincide, set wins.
  - Flags never self-clear.
- Streaming: back-to-back vectors (columns valid every cycle) are sustained at 1 vector/cycle with i_rdy held high.
- Reset mid-operation: in-flight delay-line contents and FIFO contents are discarded. Outputs return to their reset values asynchronously.

Decomposition:
- Shared package sa_pkg holds:
  - default N, X_WIDTH, Y_WIDTH constants
  - a function returning the delay depth N-1-j for column j
  - the sa_vec_t typedef (N x Y_WIDTH packed vector)
  The PE array top and the upstream skew feeder reuse this package.
- One sub-module, sa_sync_fifo (WIDTH, DEPTH parameters), provides:
  - push/full/pop/empty
  - count output
  - registered data output
  Delay lines and error logic stay in sa_col_deskew.

Test Plan:
- Single vector, N=4: drive column j valid at cycle 10+j with data j+1 (1,2,3,4) -> o_vld rises after edge 14; o_data slices = {1,2,3,4}; o_count=1; pop with i_rdy -> o_count=0, o_vld=0.
- Streaming: 16 consecutive skewed vectors, vector k column j = 100*k+j, i_rdy=1 -> 16 vectors out in order on consecutive cycles, no errors, o_count never exceeds 1.
- Overflow, DEPTH=8: 10 vectors with i_rdy=0 -> o_count=8, o_overflow=1; then drain -> vectors 0..7 exactly; pulse i_clr_err -> o_overflow=0.
- Full with simultaneous pop: fill to 8, then push vector 8 while i_rdy=1 -> accepted, count stays 8, no overflow, order preserved.
- Skew error: column 2 valid suppressed for one vector -> o_skew_err=1, that vector not written; neighbouring vectors intact; clear and set in the same cycle -> flag stays 1.
- Reset mid-stream: assert rst_n=0 with 3 vectors buffered and 2 in flight -> o_vld=0, o_count=0 immediately; after release, a new vector outputs correctly with no stale data.
